// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter; expired flags the cycle in which the count reaches MAX_COUNT.
module fetch_timeout_ctr #(
  parameter int MAX_COUNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX_COUNT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(MAX_COUNT))) begin
      count <= count + W'(1);
    end
  end

  // Raised in the cycle whose increment lands on MAX_COUNT, so the caller can act on that same edge.
  assign expired = (count == W'(MAX_COUNT)) || (en && (count == W'(MAX_COUNT - 1)));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: steps the external PC, fetches over imem req/ack, and hands
// instructions to decode through a one-entry buffer.
module fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0] RESET_INSTR    = XLEN'(NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            increment_en,
  output logic            branch_en,
  output logic [XLEN-1:0] branch_offset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_offset,
  output logic            fetch_fault,
  output fetch_state_t    state_dbg
);

  // Handshakes: imem_req/imem_addr hold until the cycle imem_ack=1 (ack may share the
  // request's first cycle); instr_valid/instr hold until the cycle instr_ready=1.
  fetch_state_t state;
  logic         discard;
  logic         ack_cycle;
  logic         redirect_take;
  logic         launch;
  logic         expired;
  logic         ctr_clr;
  logic         ctr_en;

  assign ack_cycle     = (state == FETCH) && imem_req && imem_ack;
  assign redirect_take = redirect_valid && ((state == FETCH) || (state == HOLD));

  // A redirect moves the PC on this edge, so a launch waits one cycle to see the new pc.
  assign launch = (state == IDLE)
               || ((state == FETCH) && !imem_req && !redirect_valid)
               || ((state == HOLD) && instr_ready && !redirect_valid);

  assign increment_en  = ack_cycle && !discard && !redirect_valid;
  assign branch_en     = redirect_take;
  assign branch_offset = redirect_take ? redirect_offset : '0;
  assign state_dbg     = state;

  assign ctr_clr = launch || ack_cycle;
  assign ctr_en  = (state == FETCH) && imem_req && !imem_ack;

  fetch_timeout_ctr #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= RESET_INSTR;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      discard     <= 1'b0;
    end else if (launch) begin
      instr_valid <= 1'b0;
      if (pc[1:0] != 2'b00) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
        imem_req    <= 1'b0;
      end else begin
        state     <= FETCH;
        imem_addr <= pc;
        imem_req  <= 1'b1;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack_cycle) begin
            imem_req <= 1'b0;
            discard  <= 1'b0;
            if (redirect_valid || discard) begin
              instr_valid <= 1'b0;
              if (redirect_valid) instr <= RESET_INSTR;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (imem_req && expired) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
            imem_req    <= 1'b0;
            discard     <= 1'b0;
          end else if (redirect_valid) begin
            // Only an outstanding request leaves a stale ack to swallow.
            discard     <= imem_req;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            instr       <= RESET_INSTR;
            state       <= FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus a randomized decode-stream run against an address-level model.
module tb_fetch_sequencer;
  import riscv_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pc;
  logic         increment_en, branch_en, imem_req, imem_ack;
  logic [31:0]  branch_offset, imem_addr, imem_rdata, instr, redirect_offset;
  logic         instr_valid, instr_ready, redirect_valid, fetch_fault;
  fetch_state_t state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 0;
  int req_age  = 0;
  bit mem_auto = 1'b1;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .increment_en    (increment_en),
    .branch_en       (branch_en),
    .branch_offset   (branch_offset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ack        (imem_ack),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_offset (redirect_offset),
    .fetch_fault     (fetch_fault),
    .state_dbg       (state_dbg)
  );

  // clock / reset / environment
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ProgramCounter: +4 on increment, pc+offset on branch.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h0;
    else if (branch_en) pc <= pc + branch_offset;
    else if (increment_en) pc <= pc + PC_STEP;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return {~a[15:0], a[15:0]};
  endfunction

  // Instruction memory: acks after mem_lat waiting cycles of a held request.
  always @(negedge clk) begin
    if (mem_auto) begin
      if (imem_req) begin
        if (req_age >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          req_age    = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hdeadbeef;
          req_age++;
        end
      end else begin
        imem_ack = 1'b0;
        req_age  = 0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_offset = '0;
    imem_ack = 1'b0; imem_rdata = '0; mem_auto = 1'b1; mem_lat = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({imem_req, increment_en, branch_en, instr_valid, fetch_fault, imem_addr, branch_offset, instr}
        !== {5'b0, 32'h0, 32'h0, NOP})
      $display("FAIL reset_vals got req/inc/br/val/flt=%b addr=%h off=%h instr=%h", {imem_req, increment_en, branch_en, instr_valid, fetch_fault}, imem_addr, branch_offset, instr);
    else n_pass++;
    n_checks++;
    if (state_dbg !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    @(negedge clk); #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
    n_checks++;
    if ({increment_en, branch_en, instr_valid} !== 3'b100) $display("FAIL first_inc got inc/br/val=%b exp=100", {increment_en, branch_en, instr_valid}); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({instr_valid, instr} !== {1'b1, 32'h00500093}) $display("FAIL first_instr got val=%b instr=%h exp val=1 instr=00500093", instr_valid, instr); else n_pass++;
    n_checks++;
    if ({increment_en, imem_req, pc} !== {2'b00, 32'h4}) $display("FAIL first_after got inc=%b req=%b pc=%h exp inc=0 req=0 pc=4", increment_en, imem_req, pc); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] held;
    mem_lat = 3;
    @(negedge clk); instr_ready = 1'b1; #1;
    n_checks++;
    if (instr_valid !== 1'b1) $display("FAIL stall_pre_valid got=%b exp=1", instr_valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); instr_ready = 1'b0; #1;
      n_checks++;
      if ({imem_req, imem_addr, increment_en} !== {1'b1, 32'h4, (k == 3)})
        $display("FAIL stall_req%0d got req=%b addr=%h inc=%b exp req=1 addr=4 inc=%b", k, imem_req, imem_addr, increment_en, (k == 3));
      else n_pass++;
    end
    held = mem_word(32'h4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({instr_valid, instr, imem_req} !== {1'b1, held, 1'b0})
        $display("FAIL stall_hold%0d got val=%b instr=%h req=%b exp val=1 instr=%h req=0", k, instr_valid, instr, imem_req, held);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_outstanding();
    bit bad = 0;
    bit found = 0;
    @(negedge clk); instr_ready = 1'b1;
    @(negedge clk); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_offset = 32'h10; #1;
    n_checks++;
    if ({imem_req, imem_addr, branch_en, branch_offset, increment_en} !== {1'b1, 32'h8, 1'b1, 32'h10, 1'b0})
      $display("FAIL redir_pulse got req=%b addr=%h br=%b off=%h inc=%b exp 1/8/1/10/0", imem_req, imem_addr, branch_en, branch_offset, increment_en);
    else n_pass++;
    @(negedge clk); redirect_valid = 1'b0; redirect_offset = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (instr_valid || increment_en) bad = 1;
      if (imem_req && (imem_addr == 32'h18)) found = 1;
    end
    n_checks++;
    if (bad) $display("FAIL redir_drop got stale data accepted exp none"); else n_pass++;
    n_checks++;
    if (!found) $display("FAIL redir_newaddr got no request to 00000018 within 20 cycles"); else n_pass++;
    for (int k = 0; k < 10 && !instr_valid; k++) begin @(negedge clk); #1; end
    n_checks++;
    if ({instr_valid, instr, pc} !== {1'b1, mem_word(32'h18), 32'h1c})
      $display("FAIL redir_refetch got val=%b instr=%h pc=%h exp 1/%h/1c", instr_valid, instr, pc, mem_word(32'h18));
    else n_pass++;
  endtask

  task automatic test_redirect_with_ack();
    bit found = 0;
    mem_lat = 0;
    @(negedge clk); instr_ready = 1'b1;
    @(negedge clk); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_offset = 32'h20; #1;
    n_checks++;
    if ({imem_req, imem_ack, imem_addr, branch_en, increment_en} !== {2'b11, 32'h1c, 2'b10})
      $display("FAIL ack_redir got req=%b ack=%b addr=%h br=%b inc=%b exp 1/1/1c/1/0", imem_req, imem_ack, imem_addr, branch_en, increment_en);
    else n_pass++;
    @(negedge clk); redirect_valid = 1'b0; redirect_offset = '0; #1;
    n_checks++;
    if ({instr_valid, instr} !== {1'b0, NOP}) $display("FAIL ack_redir_drop got val=%b instr=%h exp val=0 instr=%h", instr_valid, instr, NOP); else n_pass++;
    for (int k = 0; k < 5 && !found; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (imem_req && (imem_addr == 32'h3c)) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL ack_redir_newaddr got no request to 0000003c within 5 cycles"); else n_pass++;
    for (int k = 0; k < 10 && !instr_valid; k++) begin @(negedge clk); #1; end
    n_checks++;
    if ({instr_valid, instr, pc} !== {1'b1, mem_word(32'h3c), 32'h40})
      $display("FAIL ack_redir_refetch got val=%b instr=%h pc=%h exp 1/%h/40", instr_valid, instr, pc, mem_word(32'h3c));
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit stayed = 1;
    mem_lat = 1000;
    @(negedge clk); instr_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); instr_ready = 1'b0; #1;
      if (!(imem_req && !fetch_fault && (imem_addr == 32'h40))) stayed = 0;
    end
    n_checks++;
    if (!stayed) $display("FAIL timeout_wait got early drop or fault within 16 cycles exp request held"); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({fetch_fault, imem_req} !== 2'b10) $display("FAIL timeout_fault got flt=%b req=%b exp flt=1 req=0", fetch_fault, imem_req); else n_pass++;
    mem_auto = 1'b0;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h12345678; redirect_valid = 1'b1; redirect_offset = 32'h8; #1;
    n_checks++;
    if ({branch_en, increment_en, branch_offset} !== {2'b00, 32'h0}) $display("FAIL fault_ignore got br=%b inc=%b off=%h exp 0/0/0", branch_en, increment_en, branch_offset); else n_pass++;
    @(negedge clk); imem_ack = 1'b0; redirect_valid = 1'b0; redirect_offset = '0; #1;
    n_checks++;
    if ({fetch_fault, imem_req, instr_valid} !== 3'b100 || state_dbg !== FAULT)
      $display("FAIL fault_sticky got flt/req/val=%b state=%0d exp 100 state=%0d", {fetch_fault, imem_req, instr_valid}, state_dbg, FAULT);
    else n_pass++;
    mem_auto = 1'b1; mem_lat = 0;
    #2; rst_n = 1'b0; #1;
    n_checks++;
    if ({fetch_fault, imem_req, instr, state_dbg} !== {2'b00, NOP, IDLE}) $display("FAIL fault_clear got flt=%b req=%b instr=%h state=%0d", fetch_fault, imem_req, instr, state_dbg); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL fault_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b1) $display("FAIL areset_pre_hold got val=%b exp=1", instr_valid); else n_pass++;
    #2; rst_n = 1'b0; #1;
    n_checks++;
    if ({imem_req, increment_en, branch_en, instr_valid, fetch_fault, imem_addr, branch_offset, instr}
        !== {5'b0, 32'h0, 32'h0, NOP})
      $display("FAIL areset_hold got req/inc/br/val/flt=%b addr=%h off=%h instr=%h", {imem_req, increment_en, branch_en, instr_valid, fetch_fault}, imem_addr, branch_offset, instr);
    else n_pass++;
    @(negedge clk); mem_lat = 5; rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL areset_pre_fetch got req=%b exp=1", imem_req); else n_pass++;
    #2; rst_n = 1'b0; #1;
    n_checks++;
    if ({imem_req, increment_en, branch_en, instr_valid, fetch_fault, imem_addr, branch_offset, instr}
        !== {5'b0, 32'h0, 32'h0, NOP})
      $display("FAIL areset_fetch got req/inc/br/val/flt=%b addr=%h off=%h instr=%h", {imem_req, increment_en, branch_en, instr_valid, fetch_fault}, imem_addr, branch_offset, instr);
    else n_pass++;
    @(negedge clk); mem_lat = 0; rst_n = 1'b1;
  endtask

  // Model: exp_pc is the address of the next instruction decode should receive.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] offs;
    logic [31:0] exp_w;
    bit do_redir;
    int delivered = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!imem_req) mem_lat = $urandom_range(0, 4);
      do_redir = instr_valid && ($urandom_range(0, 5) == 0);
      offs = 32'($urandom_range(1, 8)) * 32'd4;
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = do_redir;
      redirect_offset = do_redir ? offs : $urandom;
      #1;
      if (instr_valid) begin
        n_checks++;
        if (pc !== exp_pc + 32'd4) $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc, exp_pc + 32'd4); else n_pass++;
      end
      if (do_redir) begin
        n_checks++;
        if ({branch_en, branch_offset, increment_en} !== {1'b1, offs, 1'b0})
          $display("FAIL rnd_redir cyc=%0d got br=%b off=%h inc=%b exp 1/%h/0", cyc, branch_en, branch_offset, increment_en, offs);
        else n_pass++;
        exp_pc = exp_pc + 32'd4 + offs;
      end else begin
        n_checks++;
        if ({branch_en, branch_offset, fetch_fault} !== {1'b0, 32'h0, 1'b0})
          $display("FAIL rnd_quiet cyc=%0d got br=%b off=%h flt=%b exp 0/0/0", cyc, branch_en, branch_offset, fetch_fault);
        else n_pass++;
        if (instr_valid && instr_ready) begin
          exp_q.push_back(mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          exp_w = exp_q.pop_front();
          delivered++;
          n_checks++;
          if (instr !== exp_w) $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", cyc, instr, exp_w); else n_pass++;
        end
      end
    end
    @(negedge clk); redirect_valid = 1'b0; redirect_offset = '0; instr_ready = 1'b0;
    n_checks++;
    if (delivered < 20) $display("FAIL rnd_progress got=%0d delivered exp>=20", delivered); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the ProgramCounter control inputs (increment_en, branch_en, branch_offset) and consumes its pc output.
- Fetches each instruction from a variable-latency instruction memory using a req/ack handshake.
- Presents the fetched instruction to decode through a one-entry valid/ready buffer.
- Sits between ProgramCounter, instruction memory and decode. It is the controlling end of the PC interface.

Parameters:
- XLEN, 32, width of pc, address, instruction and offset.
- TIMEOUT_CYCLES, 16, maximum number of cycles an imem request may wait for ack before a fault is raised.
- RESET_INSTR, 32'h00000013, value held on instr during reset and after a flush (RISC-V NOP).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  XLEN  current PC from ProgramCounter.
- increment_en  out  1  one-cycle pulse; PC advances by 4 at this edge.
- branch_en  out  1  one-cycle pulse; PC loads its branch value at this edge.
- branch_offset  out  XLEN  offset presented to ProgramCounter; valid while branch_en=1.
- imem_req  out  1  instruction memory request.
- imem_addr  out  XLEN  request address; stable while imem_req=1.
- imem_rdata  in  XLEN  instruction data; valid when imem_ack=1.
- imem_ack  in  1  request completion; may arrive in the same cycle as the request.
- instr_valid  out  1  instr holds a valid instruction.
- instr  out  XLEN  fetched instruction.
- instr_ready  in  1  decode accepts instr.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_offset  in  XLEN  offset applied on redirect.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - imem_req, increment_en, branch_en, instr_valid and fetch_fault = 0.
  - imem_addr = 0, branch_offset = 0, instr = RESET_INSTR.
  - Timeout counter and discard flag = 0.
  - Assertion of rst_n=0 mid-transaction abandons any outstanding request with no further ack bookkeeping.
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: moves to FETCH on the first clk edge after rst_n deasserts.
- Entry to FETCH:
  - Latch imem_addr = pc and raise imem_req.
  - If pc[1:0] != 0, go to FAULT instead.
- In FETCH:
  - imem_req stays high and imem_addr stays stable until imem_ack.
  - On imem_ack with no redirect and discard=0:
    - increment_en=1 combinationally in that cycle.
    - instr <= imem_rdata and instr_valid <= 1.
    - Next state HOLD; imem_req drops next cycle.
  - Zero-wait ack (same cycle as entry) is legal and handled identically.
- Timeout: the counter increments each FETCH cycle without ack. When it reaches TIMEOUT_CYCLES:
  - Go to FAULT.
  - fetch_fault <= 1.
  - imem_req <= 0.
- In HOLD:
  - instr_valid=1 and instr is stable.
  - On instr_valid & instr_ready: instr_valid <= 0, next state FETCH; the PC has already advanced.
- Redirect (any state except IDLE and FAULT):
  - branch_en=1 and branch_offset=redirect_offset combinationally in the same cycle.
  - increment_en is forced 0; branch wins and the two are never both 1.
  - instr_valid <= 0 and instr <= RESET_INSTR.
  - In HOLD, or in FETCH with ack in the same cycle: data is discarded; next state FETCH with a fresh pc.
  - In FETCH without ack: the request stays outstanding.
    - Set discard <= 1.
    - The next ack completes the old request: data dropped, no increment_en, discard cleared, FETCH re-entered with the new pc.
  - A second redirect while discard=1 still pulses branch_en; discard stays 1.
- FAULT: absorbing state.
  - All handshake outputs 0; redirects ignored.
  - Left only by reset.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Clears on every FETCH entry and on every ack.

Decomposition:
- Shared package riscv_fetch_pkg holds:
  - state enum fetch_state_t {IDLE, FETCH, HOLD, FAULT};
  - NOP_INSTR = 32'h00000013;
  - PC_STEP = 4.
- One sub-module, fetch_timeout_ctr: a parameterised saturating counter with clear, enable and expired outputs. All other logic stays in fetch_sequencer.

Test Plan:
1. Reset, then a zero-wait imem returning 32'h00500093 at pc=0:
   - imem_req=1 with imem_addr=0 one cycle after rst_n rises.
   - increment_en pulses once.
   - instr_valid=1 with instr=32'h00500093.
2. Ack delayed 3 cycles, then decode holds instr_ready=0 for 4 cycles:
   - imem_addr stays stable for all 4 request cycles.
   - instr stays stable while stalled.
   - No second imem_req until instr_ready=1.
3. redirect_valid with offset 32'h00000010 while a FETCH is outstanding:
   - branch_en pulses that cycle with branch_offset=0x10 and increment_en=0.
   - The late ack data is dropped and instr_valid stays 0.
   - The next request uses the redirected pc.
4. redirect_valid in the same cycle as imem_ack:
   - branch_en=1 and increment_en=0.
   - instr_valid stays 0; refetch starts next cycle.
5. No ack for 16 cycles:
   - fetch_fault=1 after cycle 16 and imem_req=0.
   - Later acks and redirects are ignored.
   - rst_n low clears the fault and restarts from IDLE.
6. rst_n asserted mid-HOLD and mid-FETCH:
   - All outputs reach reset values immediately, without waiting for a clk edge.
